// File: rtl/stoch_signed_nmax_tree.sv
// rtl/stoch_signed_nmax_tree.sv - pipelined signed stochastic max/min tree with argmax
// Balanced binary tree of registered saturating-counter comparators; latency = LEVELS cycles.
module stoch_signed_nmax_tree #(
   parameter  int NUM_INPUTS  = 4,
   parameter  int COUNT_WIDTH = 8,
   parameter  int MODE        = 0,
   localparam int LEVELS      = $clog2(NUM_INPUTS),
   localparam int IDX_W       = (LEVELS < 1) ? 1 : LEVELS
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  clr,
   input  logic [NUM_INPUTS-1:0] as_p,
   input  logic [NUM_INPUTS-1:0] as_m,
   output logic                  y_p,
   output logic                  y_m,
   output logic [IDX_W-1:0]      y_idx
);

   function automatic int f_nodes(input int lvl);
      int n;
      n = NUM_INPUTS;
      for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
      return n;
   endfunction

   logic             w_p   [0:LEVELS][0:NUM_INPUTS-1];
   logic             w_m   [0:LEVELS][0:NUM_INPUTS-1];
   logic [IDX_W-1:0] w_idx [0:LEVELS][0:NUM_INPUTS-1];

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : gen_in
      assign w_p[0][i]   = as_p[i];
      assign w_m[0][i]   = as_m[i];
      assign w_idx[0][i] = IDX_W'(i);
   end

   for (genvar l = 1; l <= LEVELS; l++) begin : gen_lvl
      localparam int NP = f_nodes(l - 1);
      localparam int NN = f_nodes(l);
      for (genvar j = 0; j < NUM_INPUTS; j++) begin : gen_node
         if (j >= NN) begin : gen_unused
            assign w_p[l][j]   = 1'b0;
            assign w_m[l][j]   = 1'b0;
            assign w_idx[l][j] = '0;
         end else if (2 * j + 1 < NP) begin : gen_cmp
            logic                   r_p;
            logic                   r_m;
            logic [IDX_W-1:0]       r_idx;
            logic [COUNT_WIDTH-1:0] r_cnt;
            logic signed [2:0]      w_da;
            logic signed [2:0]      w_db;
            logic signed [2:0]      w_d;
            logic [COUNT_WIDTH:0]   w_sum;
            logic [COUNT_WIDTH-1:0] w_sat;
            logic                   w_sel_a;

            assign w_da  = $signed({2'b00, w_p[l-1][2*j]})   - $signed({2'b00, w_m[l-1][2*j]});
            assign w_db  = $signed({2'b00, w_p[l-1][2*j+1]}) - $signed({2'b00, w_m[l-1][2*j+1]});
            assign w_d   = w_da - w_db;
            assign w_sum = {r_cnt[COUNT_WIDTH-1], r_cnt} + {{(COUNT_WIDTH-2){w_d[2]}}, w_d};
            // |d| <= 2 so a single guard bit detects overflow; clamp toward its sign
            assign w_sat = (w_sum[COUNT_WIDTH] != w_sum[COUNT_WIDTH-1]) ?
                           (w_sum[COUNT_WIDTH] ? {1'b1, {(COUNT_WIDTH-1){1'b0}}}
                                               : {1'b0, {(COUNT_WIDTH-1){1'b1}}})
                           : w_sum[COUNT_WIDTH-1:0];
            assign w_sel_a = (MODE == 0) ? !r_cnt[COUNT_WIDTH-1]
                                         : (r_cnt[COUNT_WIDTH-1] || (r_cnt == '0));

            always_ff @(posedge CLK or negedge nRST) begin
               if (!nRST) begin
                  r_p   <= 1'b0;
                  r_m   <= 1'b0;
                  r_idx <= '0;
                  r_cnt <= '0;
               end else begin
                  r_p   <= w_sel_a ? w_p[l-1][2*j]   : w_p[l-1][2*j+1];
                  r_m   <= w_sel_a ? w_m[l-1][2*j]   : w_m[l-1][2*j+1];
                  r_idx <= w_sel_a ? w_idx[l-1][2*j] : w_idx[l-1][2*j+1];
                  r_cnt <= clr ? '0 : w_sat;
               end
            end

            assign w_p[l][j]   = r_p;
            assign w_m[l][j]   = r_m;
            assign w_idx[l][j] = r_idx;
         end else begin : gen_pass
            logic             r_p;
            logic             r_m;
            logic [IDX_W-1:0] r_idx;

            always_ff @(posedge CLK or negedge nRST) begin
               if (!nRST) begin
                  r_p   <= 1'b0;
                  r_m   <= 1'b0;
                  r_idx <= '0;
               end else begin
                  r_p   <= w_p[l-1][2*j];
                  r_m   <= w_m[l-1][2*j];
                  r_idx <= w_idx[l-1][2*j];
               end
            end

            assign w_p[l][j]   = r_p;
            assign w_m[l][j]   = r_m;
            assign w_idx[l][j] = r_idx;
         end
      end
   end

   assign y_p   = w_p[LEVELS][0];
   assign y_m   = w_m[LEVELS][0];
   assign y_idx = w_idx[LEVELS][0];

endmodule

// File: tb/tb_stoch_signed_nmax_tree.sv
// tb/tb_stoch_signed_nmax_tree.sv - randomized and directed checks of four tree configurations
// Instances: max(N4,CW8), min(N4,CW8), sat(N4,CW4), odd(N3,CW8); all share stimulus.
module tb_stoch_signed_nmax_tree;

   logic       CLK = 1'b0;
   logic       nRST;
   logic       clr;
   logic [3:0] st_p;
   logic [3:0] st_m;
   logic [3:0] yp;
   logic [3:0] ym;
   logic [1:0] yi [4];

   int    n_chk  = 0;
   int    n_fail = 0;
   int    n_k  [4] = '{4, 4, 4, 3};
   int    cw_k [4] = '{8, 8, 4, 8};
   int    md_k [4] = '{0, 1, 0, 0};
   string nm   [4] = '{"max", "min", "sat", "odd"};

   int mv_p [4][3][4];
   int mv_m [4][3][4];
   int mv_i [4][3][4];
   int mcnt [4][3][4];
   int pref [4];

   always #5 CLK = ~CLK;

   stoch_signed_nmax_tree #(.NUM_INPUTS(4), .COUNT_WIDTH(8), .MODE(0)) u_max (
      .CLK(CLK), .nRST(nRST), .clr(clr), .as_p(st_p), .as_m(st_m),
      .y_p(yp[0]), .y_m(ym[0]), .y_idx(yi[0]));
   stoch_signed_nmax_tree #(.NUM_INPUTS(4), .COUNT_WIDTH(8), .MODE(1)) u_min (
      .CLK(CLK), .nRST(nRST), .clr(clr), .as_p(st_p), .as_m(st_m),
      .y_p(yp[1]), .y_m(ym[1]), .y_idx(yi[1]));
   stoch_signed_nmax_tree #(.NUM_INPUTS(4), .COUNT_WIDTH(4), .MODE(0)) u_sat (
      .CLK(CLK), .nRST(nRST), .clr(clr), .as_p(st_p), .as_m(st_m),
      .y_p(yp[2]), .y_m(ym[2]), .y_idx(yi[2]));
   stoch_signed_nmax_tree #(.NUM_INPUTS(3), .COUNT_WIDTH(8), .MODE(0)) u_odd (
      .CLK(CLK), .nRST(nRST), .clr(clr), .as_p(st_p[2:0]), .as_m(st_m[2:0]),
      .y_p(yp[3]), .y_m(ym[3]), .y_idx(yi[3]));

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++)
         for (int l = 0; l < 3; l++)
            for (int j = 0; j < 4; j++) begin
               mv_p[k][l][j] = 0;
               mv_m[k][l][j] = 0;
               mv_i[k][l][j] = 0;
               mcnt[k][l][j] = 0;
            end
   endtask

   // Signed value per channel: +1 -> (1,0), -1 -> (0,1), 0 -> (0,0)
   task automatic set_ch(input int i, input int v);
      st_p[i] = (v > 0);
      st_m[i] = (v < 0);
   endtask

   task automatic set_all(input int v0, input int v1, input int v2, input int v3);
      set_ch(0, v0); set_ch(1, v1); set_ch(2, v2); set_ch(3, v3);
   endtask

   task automatic model_step(input int k);
      int np, ap, am, ai, bp, bm, bi, d, c, lim;
      bit sel;
      for (int l = 2; l >= 1; l--) begin
         np = (l == 1) ? n_k[k] : (n_k[k] + 1) / 2;
         for (int j = 0; 2 * j < np; j++) begin
            if (l == 1) begin
               ap = int'(st_p[2*j]); am = int'(st_m[2*j]); ai = 2 * j;
            end else begin
               ap = mv_p[k][1][2*j]; am = mv_m[k][1][2*j]; ai = mv_i[k][1][2*j];
            end
            if (2 * j + 1 < np) begin
               if (l == 1) begin
                  bp = int'(st_p[2*j+1]); bm = int'(st_m[2*j+1]); bi = 2 * j + 1;
               end else begin
                  bp = mv_p[k][1][2*j+1]; bm = mv_m[k][1][2*j+1]; bi = mv_i[k][1][2*j+1];
               end
               d   = (ap - am) - (bp - bm);
               c   = mcnt[k][l][j];
               sel = (md_k[k] == 0) ? (c >= 0) : (c <= 0);
               if (!sel) begin ap = bp; am = bm; ai = bi; end
               lim = 1 << (cw_k[k] - 1);
               c = c + d;
               if (c > lim - 1) c = lim - 1;
               if (c < -lim) c = -lim;
               mcnt[k][l][j] = clr ? 0 : c;
            end
            mv_p[k][l][j] = ap;
            mv_m[k][l][j] = am;
            mv_i[k][l][j] = ai;
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s_p", nm[k]),   int'(yp[k]), mv_p[k][2][0]);
         chk($sformatf("%s_m", nm[k]),   int'(ym[k]), mv_m[k][2][0]);
         chk($sformatf("%s_idx", nm[k]), int'(yi[k]), mv_i[k][2][0]);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      if (!nRST) model_reset();
      else for (int k = 0; k < 4; k++) model_step(k);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      model_reset();
      tick();
      nRST = 1'b1;
   endtask

   task automatic chk_out(input string tag, input int k, input int p, input int m, input int idx);
      chk({tag, "_p"},   int'(yp[k]), p);
      chk({tag, "_m"},   int'(ym[k]), m);
      chk({tag, "_idx"}, int'(yi[k]), idx);
   endtask

   initial begin
      nRST = 1'b0;
      clr  = 1'b0;
      st_p = 4'($urandom);
      st_m = 4'($urandom);
      model_reset();

      // Reset held with random inputs, then release
      for (int c = 0; c < 3; c++) begin
         tick();
         for (int k = 0; k < 4; k++) chk_out($sformatf("rst_hold_%s", nm[k]), k, 0, 0, 0);
         st_p = 4'($urandom);
         st_m = 4'($urandom);
      end
      nRST = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) chk_out($sformatf("rst_fill_%s", nm[k]), k, 0, 0, 0);
      tick();

      // Max / min with constant (-1, 0, +1, 0)
      do_reset();
      set_all(-1, 0, 1, 0);
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c >= 10) begin
            chk_out("max_const", 0, 1, 0, 2);
            chk_out("min_const", 1, 0, 1, 0);
         end
      end

      // Saturation then reversal on the 4-bit counter instance
      do_reset();
      set_all(1, -1, -1, -1);
      for (int c = 1; c <= 100; c++) begin
         tick();
         chk("sat_pre_idx", int'(yi[2]), 0);
      end
      set_all(-1, 1, -1, -1);
      for (int e = 1; e <= 6; e++) begin
         tick();
         chk($sformatf("sat_flip_e%0d", e), int'(yi[2]), (e < 6) ? 0 : 1);
      end

      // clr shortens recovery
      do_reset();
      set_all(1, 0, 0, 0);
      for (int c = 0; c < 50; c++) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      set_all(0, 1, 0, 0);
      for (int e = 0; e < 4; e++) tick();
      chk("clr_recover_idx", int'(yi[0]), 1);

      // Odd width: (0, 0, +1), then single-cycle pulse on input 2
      do_reset();
      set_all(0, 0, 1, 0);
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c >= 4) begin
            chk("odd_idx", int'(yi[3]), 2);
            chk("odd_p", int'(yp[3]), 1);
         end
      end
      set_ch(2, 0);
      for (int c = 0; c < 3; c++) tick();
      set_ch(2, 1);
      tick();
      chk("odd_pulse_e1", int'(yp[3]), 0);
      set_ch(2, 0);
      tick();
      chk("odd_pulse_e2", int'(yp[3]), 1);
      tick();
      chk("odd_pulse_e3", int'(yp[3]), 0);

      // Randomized run with biased channels, sporadic clr and one async reset
      for (int i = 0; i < 4; i++) pref[i] = $urandom_range(0, 2) - 1;
      for (int c = 0; c < 1500; c++) begin
         if (c % 100 == 0)
            for (int i = 0; i < 4; i++) pref[i] = $urandom_range(0, 2) - 1;
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 7) < 5) set_ch(i, pref[i]);
            else begin
               st_p[i] = 1'($urandom);
               st_m[i] = 1'($urandom);
            end
         end
         clr = ($urandom_range(0, 63) == 0);
         if (c == 700) begin
            #2;
            nRST = 1'b0;
            model_reset();
            #1;
            for (int k = 0; k < 4; k++) chk_out($sformatf("async_rst_%s", nm[k]), k, 0, 0, 0);
            tick();
            nRST = 1'b1;
         end
         tick();
      end
      clr = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
